// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
// Fetch FSM encoding, datapath width and reset-time defaults.
package pc_fetch_ctrl_pkg;

  localparam int CPU_XLEN = 32;
  localparam logic [CPU_XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [CPU_XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    KILL = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/pc_fetch_ctrl.sv
// IF-stage fetch controller: owns the fetch PC, issues one imem request at a time,
// and hands {pc, instr} to IF/ID through a single-entry buffer.
//
// state | meaning
// REQ   | nothing in flight; request pc_q when the output buffer can accept
// WAIT  | one fetch in flight; its response fills the buffer
// KILL  | one stale fetch in flight (redirected); its response is discarded
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter int XLEN = CPU_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            if_valid_o,
  output logic [XLEN-1:0] if_pc_o,
  output logic [XLEN-1:0] if_instr_o,
  output logic            flush_o,
  output logic            misalign_o
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] inflight_pc_q;
  logic            buf_free;
  logic            handshake;
  logic            fill;

  assign buf_free    = !if_valid_o || !stall_i;
  assign handshake   = imem_req_o && imem_gnt_i;
  assign fill        = (state_q == WAIT) && imem_rvalid_i && !redirect_i;
  assign flush_o     = redirect_i;
  assign imem_addr_o = pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= REQ;
    else        state_q <= state_d;
  end

  // rvalid while in REQ is a protocol violation and is simply ignored.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      REQ: begin
        if (handshake) state_d = redirect_i ? KILL : WAIT;
      end
      WAIT: begin
        if (imem_rvalid_i)   state_d = REQ;
        else if (redirect_i) state_d = KILL;
      end
      KILL: begin
        if (imem_rvalid_i) state_d = REQ;
      end
      default: state_d = REQ;
    endcase
  end

  always_comb begin
    imem_req_o = (state_q == REQ) && buf_free;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      inflight_pc_q <= '0;
      misalign_o    <= 1'b0;
    end else begin
      misalign_o <= redirect_i && redirect_pc_i[1];
      if (handshake) inflight_pc_q <= pc_q;
      // A redirect always wins; a killed fetch never advances the PC.
      if (redirect_i)     pc_q <= redirect_pc_i;
      else if (handshake) pc_q <= pc_q + XLEN'(4);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_valid_o <= 1'b0;
      if_pc_o    <= '0;
      if_instr_o <= '0;
    end else if (redirect_i) begin
      if_valid_o <= 1'b0;
    end else if (fill) begin
      if_valid_o <= 1'b1;
      if_pc_o    <= inflight_pc_q;
      if_instr_o <= imem_rdata_i;
    end else if (if_valid_o && !stall_i) begin
      if_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios plus a randomized run,
// all compared against a transaction-level model of the fetch unit.
module tb_pc_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        flush;
  logic        misalign;

  int errors = 0;
  int checks = 0;

  // model: fetch pc, output buffer, one outstanding fetch (with killed flag)
  logic [31:0] m_fpc, m_bpc, m_instr, o_addr;
  logic        m_valid, m_mis, o_busy, o_killed;
  // memory responder
  logic        mem_busy;
  logic [31:0] mem_addr;
  int          mem_lat;
  int          lat_next;
  // values captured just before the clock edge
  logic        c_req, c_flush, e_req;
  logic [31:0] c_addr, e_addr;

  pc_fetch_ctrl #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall), .redirect_i(redirect),
    .redirect_pc_i(redirect_pc), .imem_req_o(req), .imem_addr_o(addr),
    .imem_gnt_i(gnt), .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
    .if_valid_o(if_valid), .if_pc_o(if_pc), .if_instr_o(if_instr),
    .flush_o(flush), .misalign_o(misalign)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] memdata(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  task automatic model_reset();
    m_fpc = 32'h0; m_bpc = 32'h0; m_instr = 32'h0;
    m_valid = 1'b0; m_mis = 1'b0; o_busy = 1'b0; o_killed = 1'b0; o_addr = 32'h0;
    mem_busy = 1'b0; mem_addr = 32'h0; mem_lat = 0;
  endtask

  // One clock cycle: drive inputs at edge+1, capture comb outputs at edge-2, update model.
  task automatic step(input logic st, input logic rd, input logic [31:0] rpc, input logic g);
    logic hs, consumed;
    stall = st; redirect = rd; redirect_pc = rpc; gnt = g;
    rvalid = mem_busy && (mem_lat == 0);
    rdata  = rvalid ? memdata(mem_addr) : $urandom;
    e_req  = !o_busy && (!m_valid || !st);
    e_addr = m_fpc;
    #7;
    c_req = req; c_addr = addr; c_flush = flush;
    if (rvalid)        mem_busy = 1'b0;
    else if (mem_busy) mem_lat--;
    if (c_req && g) begin mem_busy = 1'b1; mem_addr = c_addr; mem_lat = lat_next; end
    hs = e_req && g;
    consumed = m_valid && !st;
    m_mis = rd && rpc[1];
    if (rd) m_valid = 1'b0;
    else if (rvalid && o_busy && !o_killed) begin
      m_valid = 1'b1; m_bpc = o_addr; m_instr = memdata(o_addr);
    end else if (consumed) m_valid = 1'b0;
    if (rvalid) o_busy = 1'b0;
    if (rd && o_busy) o_killed = 1'b1;
    if (hs) begin o_busy = 1'b1; o_addr = m_fpc; o_killed = rd; end
    if (rd)      m_fpc = rpc;
    else if (hs) m_fpc = m_fpc + 32'd4;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 0; redirect = 0; redirect_pc = 0; gnt = 0; rvalid = 0; rdata = 0;
    model_reset();
    lat_next = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({if_valid, if_pc, if_instr, misalign} !== 66'h0) begin
      errors++; $display("FAIL reset_outputs: got valid=%0b pc=%h instr=%h mis=%0b want all 0",
                         if_valid, if_pc, if_instr, misalign);
    end
    rst_n = 1'b1;
    #6;
    checks++;
    if (req !== 1'b1 || addr !== 32'h0) begin
      errors++; $display("FAIL reset_first_req: got req=%0b addr=%h want req=1 addr=00000000", req, addr);
    end
    @(posedge clk); #1;
    model_reset();
    // that edge already issued the fetch of address 0 (gnt was 0, so nothing was granted)
  endtask

  task automatic test_stream();
    for (int k = 1; k <= 6; k++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      if (k % 2 == 0) begin
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'(4 * (k / 2 - 1)) ||
            if_instr !== memdata(32'(4 * (k / 2 - 1)))) begin
          errors++; $display("FAIL stream_k%0d: got valid=%0b pc=%h instr=%h want pc=%h",
                             k, if_valid, if_pc, if_instr, 32'(4 * (k / 2 - 1)));
        end
      end else begin
        checks++;
        if (c_req !== 1'b1 || c_addr !== 32'(4 * (k / 2))) begin
          errors++; $display("FAIL stream_req_k%0d: got req=%0b addr=%h want addr=%h",
                             k, c_req, c_addr, 32'(4 * (k / 2)));
        end
      end
    end
  endtask

  task automatic test_stall();
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 32'h0, 1'b1);
      checks++;
      if (c_req !== 1'b0 || if_valid !== 1'b1 || if_pc !== 32'h8 || if_instr !== memdata(32'h8)) begin
        errors++; $display("FAIL stall_hold%0d: got req=%0b valid=%0b pc=%h want req=0 valid=1 pc=8",
                           k, c_req, if_valid, if_pc);
      end
    end
    lat_next = 2;
    step(1'b0, 1'b0, 32'h0, 1'b1);
    checks++;
    if (c_req !== 1'b1 || c_addr !== 32'hC) begin
      errors++; $display("FAIL stall_release: got req=%0b addr=%h want req=1 addr=0000000c", c_req, c_addr);
    end
  endtask

  task automatic test_redirect_wait();
    step(1'b0, 1'b1, 32'h100, 1'b1);
    checks++;
    if (c_flush !== 1'b1 || c_req !== 1'b0) begin
      errors++; $display("FAIL redir_wait_flush: got flush=%0b req=%0b want flush=1 req=0", c_flush, c_req);
    end
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    checks++;
    if (c_req !== 1'b0 || if_valid !== 1'b0) begin
      errors++; $display("FAIL redir_wait_drop: got req=%0b valid=%0b want 0 0", c_req, if_valid);
    end
    step(1'b0, 1'b0, 32'h0, 1'b0);
    checks++;
    if (c_req !== 1'b1 || c_addr !== 32'h100) begin
      errors++; $display("FAIL redir_wait_addr: got req=%0b addr=%h want req=1 addr=00000100", c_req, c_addr);
    end
  endtask

  task automatic test_redirect_gnt();
    lat_next = 0;
    step(1'b0, 1'b1, 32'h20, 1'b0);
    step(1'b0, 1'b1, 32'h200, 1'b1);
    checks++;
    if (c_req !== 1'b1 || c_addr !== 32'h20) begin
      errors++; $display("FAIL redir_gnt_addr: got req=%0b addr=%h want req=1 addr=00000020", c_req, c_addr);
    end
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      checks++;
      if (if_valid === 1'b1 && if_pc === 32'h20) begin
        errors++; $display("FAIL redir_gnt_stale%0d: got valid=1 pc=%h want pc never 00000020", k, if_pc);
      end
    end
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h200 || if_instr !== memdata(32'h200)) begin
      errors++; $display("FAIL redir_gnt_next: got valid=%0b pc=%h want valid=1 pc=00000200", if_valid, if_pc);
    end
  endtask

  task automatic test_misalign();
    step(1'b0, 1'b1, 32'h102, 1'b0);
    checks++;
    if (misalign !== 1'b1 || if_valid !== 1'b0) begin
      errors++; $display("FAIL misalign_pulse: got mis=%0b valid=%0b want mis=1 valid=0", misalign, if_valid);
    end
    step(1'b0, 1'b0, 32'h0, 1'b0);
    checks++;
    if (misalign !== 1'b0 || c_req !== 1'b1 || c_addr !== 32'h102) begin
      errors++; $display("FAIL misalign_fetch: got mis=%0b req=%0b addr=%h want mis=0 req=1 addr=00000102",
                         misalign, c_req, c_addr);
    end
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h102) begin
      errors++; $display("FAIL misalign_data: got valid=%0b pc=%h want valid=1 pc=00000102", if_valid, if_pc);
    end
  endtask

  task automatic test_reset_mid_wait();
    lat_next = 3;
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({if_valid, if_pc, if_instr, misalign} !== 66'h0) begin
      errors++; $display("FAIL async_reset: got valid=%0b pc=%h instr=%h mis=%0b want all 0",
                         if_valid, if_pc, if_instr, misalign);
    end
    model_reset();
    rvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    lat_next = 0;
    step(1'b0, 1'b0, 32'h0, 1'b1);
    checks++;
    if (c_req !== 1'b1 || c_addr !== 32'h0) begin
      errors++; $display("FAIL reset_refetch: got req=%0b addr=%h want req=1 addr=00000000", c_req, c_addr);
    end
    step(1'b0, 1'b0, 32'h0, 1'b0);
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== memdata(32'h0)) begin
      errors++; $display("FAIL reset_refetch_data: got valid=%0b pc=%h want valid=1 pc=00000000", if_valid, if_pc);
    end
  endtask

  task automatic test_random();
    logic st, rd, g;
    logic [31:0] r;
    for (int n = 0; n < 800; n++) begin
      st = ($urandom % 10) < 3;
      rd = ($urandom % 10) == 0;
      g  = ($urandom % 2) == 1;
      r  = $urandom;
      lat_next = $urandom_range(0, 2);
      step(st, rd, r & 32'hFFFF_FFFE, g);
      checks++;
      if (c_req !== e_req || (e_req && c_addr !== e_addr)) begin
        errors++; $display("FAIL rnd_req@%0d: got req=%0b addr=%h want req=%0b addr=%h",
                           n, c_req, c_addr, e_req, e_addr);
      end
      checks++;
      if (c_flush !== rd) begin
        errors++; $display("FAIL rnd_flush@%0d: got %0b want %0b", n, c_flush, rd);
      end
      checks++;
      if (if_valid !== m_valid || (m_valid && (if_pc !== m_bpc || if_instr !== m_instr))) begin
        errors++; $display("FAIL rnd_buf@%0d: got valid=%0b pc=%h instr=%h want valid=%0b pc=%h instr=%h",
                           n, if_valid, if_pc, if_instr, m_valid, m_bpc, m_instr);
      end
      checks++;
      if (misalign !== m_mis) begin
        errors++; $display("FAIL rnd_misalign@%0d: got %0b want %0b", n, misalign, m_mis);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_wait();
    test_redirect_gnt();
    test_misalign();
    test_reset_mid_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
